toast_sequencer: RTL and testbench
==================================

# toast_sequencer

Cycle controller for the toaster's heating timer/PWM block. It takes the keypad's cook time and shade selection plus the lever and cancel inputs. It then runs one toast cycle on the timer in three phases: a fixed full-power preheat, a timed toast phase at a duty cycle chosen by shade, and a low-power keep-warm phase. Around the cycle it drives the timer's write/acknowledge load handshake, its start enable and its duty-cycle input, handles lever-up pause/resume and cancel, and raises a done beep. It sits between the keypad/front-panel logic and the timer/PWM block.

## Interface
Parameters:
- PREHEAT_S, 20: preheat duration in seconds, loaded into the timer.
- PREHEAT_DC, 200: duty-cycle code for preheat; 200 is 100 %.
- WARM_S, 60: keep-warm duration in seconds.
- WARM_DC, 40: duty-cycle code for keep-warm.
- BEEP_CYC, 1000: number of clk cycles `beep` stays high at toast end.
- ACK_TMO, 16: cycles allowed for `tmr_ack` after `tmr_write` rises.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- go  in  1  single-cycle start request from the keypad.
- cancel  in  1  level input; abort the cycle.
- lid_closed  in  1  lever down; 0 requests a pause.
- cook_time  in  10  toast time in seconds; valid range 1..599.
- shade  in  2  selects toast duty code: 0→80, 1→120, 2→160, 3→200.
- tmr_remaining  in  12  timer's {minutes, tens, ones} BCD display value.
- tmr_ack  in  1  timer's write acknowledge.
- tmr_write  out  1  load request to the timer.
- tmr_time  out  10  seconds value to load into the timer.
- tmr_start  out  1  timer countdown/PWM enable.
- tmr_dc  out  8  duty-cycle code sent to the timer.
- busy  out  1  high in every state except IDLE and ERR.
- beep  out  1  done buzzer.
- phase  out  3  current state encoding, for the display.
- err  out  1  sticky fault flag.

## Operation
- All outputs are registered and are a Moore function of the state plus its captured registers.
- States: IDLE, LD_PRE, PRE, LD_TST, TST, LD_WRM, WRM, PAUSE, ERR.
- `phase` encodings: IDLE=0, LD_PRE=1, PRE=2, LD_TST=3, TST=4, LD_WRM=5, WRM=6, PAUSE=7. ERR also reports 7, with `err`=1 distinguishing it from PAUSE.
- IDLE:
  - `go` with cook_time in 1..599 and lid_closed=1 → LD_PRE.
  - On that transition, capture cook_time and the shade-derived duty code into internal registers; later changes on these inputs are ignored.
  - `go` with an invalid cook_time or lid_closed=0 stays in IDLE and pulses `err` for 1 cycle. This is not sticky.
- LD_x states (LD_PRE, LD_TST, LD_WRM):
  - `tmr_write`=1 and `tmr_time` is held stable at PREHEAT_S, the captured cook time or WARM_S respectively.
  - `tmr_start`=0.
  - The state is left on the first cycle `tmr_ack`=1 is sampled, moving to PRE, TST or WRM. `tmr_write` drops in the same registered update.
- Ack timeout: if ACK_TMO cycles pass without an ack → ERR.
- Run states (PRE, TST, WRM):
  - `tmr_start`=1.
  - `tmr_dc` = PREHEAT_DC in PRE, the captured duty code in TST, WARM_DC in WRM.
  - The phase ends when `tmr_remaining`==0 is sampled: PRE→LD_TST, TST→LD_WRM with `beep` started, WRM→IDLE.
  - An ack-to-zero check is not needed, because the timer's value is already loaded when the ack is seen.
- PAUSE:
  - Entered when lid_closed=0 is sampled in PRE or TST; the return state is saved.
  - `tmr_start`=0, so the timer freezes and PWM is off. `tmr_dc` holds its value.
  - lid_closed=1 returns to the saved state.
  - Lever-up during WRM → IDLE; this is a normal end with no error.
  - Lever-up during an LD_x state is ignored until the state reaches its run state.
- cancel=1 in any state except ERR → IDLE. `beep` is cleared, `tmr_start`=0 and `tmr_write`=0.
- ERR:
  - `err`=1 sticky; all timer outputs are 0.
  - Left only by cancel or rst, both → IDLE.
- Beep:
  - A counter of width clog2(BEEP_CYC+1) runs independently of the state once started. It is not restarted while running.
  - It is cleared by cancel or rst.
- Priority when events coincide: rst > cancel > ack timeout > lid_closed=0 > tmr_remaining==0 / tmr_ack.

## Timing
- Reset values: state IDLE. `tmr_write`=0, `tmr_time`=0, `tmr_start`=0, `tmr_dc`=0, `busy`=0, `beep`=0, `phase`=0, `err`=0.
- Latency, `go` sampled → `tmr_write`=1: 1 cycle.
- Latency, `tmr_ack` sampled → `tmr_start`=1: 1 cycle.
- Latency, `tmr_remaining`==0 sampled → next `tmr_write`=1: 1 cycle.
- lid_closed or cancel change → `tmr_start`=0: 1 cycle.
- While the timer handshake is in progress, `tmr_write` may stay high for 2 cycles. Reloading the same value twice is harmless.
- Ack timeout counter: cleared on entry to each LD_x state. ERR is entered on the cycle the count reaches ACK_TMO.
- rst asserted mid-cycle returns every output to its reset value immediately, without waiting for a clock edge.

## Test plan
- Normal cycle:
  - Stimulus: rst, then go with cook_time=5, shade=2; model the timer counting down.
  - Required: the sequence walks 1→2→3→4→5→6→0.
  - Required loads, in order: `tmr_time`=20, then 5, then 60.
  - Required `tmr_dc` in PRE/TST/WRM: 200, 160, 40.
  - Required: `beep` high for exactly 1000 cycles starting at the TST→LD_WRM transition.
- Invalid go:
  - cook_time=0 → 1-cycle `err` pulse, state stays 0.
  - cook_time=600 → same.
  - lid_closed=0 with a valid cook_time → same.
- Pause/resume:
  - Stimulus: lid_closed=0 for 500 cycles midway through TST.
  - Required: `phase`=7, `tmr_start`=0, `tmr_dc` still 160.
  - Required on lid close: return to phase 4 with `tmr_start`=1.
- Cancel:
  - Stimulus: cancel=1 during PRE, and separately during LD_TST.
  - Required: next cycle all timer outputs are 0, `phase`=0, `err`=0.
- Ack timeout:
  - Stimulus: tie `tmr_ack`=0 after go.
  - Required: ERR after 16 cycles, `err` stays 1 and `go` is ignored.
  - Required: cancel returns to IDLE with `err`=0.
- Async reset:
  - Stimulus: assert rst between clock edges during TST.
  - Required: all outputs go to their reset values before the next clk edge.

Source files
------------

// File: rtl/toast_sequencer.sv
// Toaster cycle controller: preheat, shade-timed toast and keep-warm phases driven
// through the timer/PWM block's load handshake, with pause, cancel, ack timeout and done beep.
module toast_sequencer #(
  parameter int PREHEAT_S  = 20,
  parameter int PREHEAT_DC = 200,
  parameter int WARM_S     = 60,
  parameter int WARM_DC    = 40,
  parameter int BEEP_CYC   = 1000,
  parameter int ACK_TMO    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic        cancel,
  input  logic        lid_closed,
  input  logic [9:0]  cook_time,
  input  logic [1:0]  shade,
  input  logic [11:0] tmr_remaining,
  input  logic        tmr_ack,
  output logic        tmr_write,
  output logic [9:0]  tmr_time,
  output logic        tmr_start,
  output logic [7:0]  tmr_dc,
  output logic        busy,
  output logic        beep,
  output logic [2:0]  phase,
  output logic        err
);

  localparam int AW = $clog2(ACK_TMO + 1);
  localparam int BW = $clog2(BEEP_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LD_PRE = 4'd1,
    S_PRE    = 4'd2,
    S_LD_TST = 4'd3,
    S_TST    = 4'd4,
    S_LD_WRM = 4'd5,
    S_WRM    = 4'd6,
    S_PAUSE  = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  function automatic logic [7:0] shade_dc(input logic [1:0] s);
    case (s)
      2'd0:    return 8'd80;
      2'd1:    return 8'd120;
      2'd2:    return 8'd160;
      default: return 8'd200;
    endcase
  endfunction

  state_t        r_state, w_state_nxt;
  state_t        r_ret, w_ret_nxt;
  state_t        w_eff;
  logic [3:0]    w_nxt_bits;
  logic [AW-1:0] r_ack_cnt, w_ack_cnt_nxt;
  logic [BW-1:0] r_beep_cnt, w_beep_nxt;
  logic [9:0]    r_cook;
  logic [7:0]    r_tdc;
  logic          w_cap, w_err_pulse, w_beep_start, w_go_ok, w_rem_zero, w_tmo;

  logic          r_tmr_write, w_tmr_write;
  logic [9:0]    r_tmr_time, w_tmr_time;
  logic          r_tmr_start, w_tmr_start;
  logic [7:0]    r_tmr_dc, w_tmr_dc;
  logic          r_busy, w_busy;
  logic          r_beep, w_beep;
  logic [2:0]    r_phase, w_phase;
  logic          r_err, w_err;

  assign w_go_ok    = lid_closed && (cook_time != 10'd0) && (cook_time < 10'd600);
  assign w_rem_zero = (tmr_remaining == 12'd0);
  assign w_tmo      = (r_ack_cnt == AW'(ACK_TMO - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_ret_nxt     = r_ret;
    w_ack_cnt_nxt = r_ack_cnt;
    w_cap         = 1'b0;
    w_err_pulse   = 1'b0;
    w_beep_start  = 1'b0;
    if (cancel) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (go) begin
            if (w_go_ok) begin
              w_state_nxt   = S_LD_PRE;
              w_cap         = 1'b1;
              w_ack_cnt_nxt = '0;
            end else begin
              w_err_pulse = 1'b1;
            end
          end
        end
        S_LD_PRE, S_LD_TST, S_LD_WRM: begin
          if (w_tmo) begin
            w_state_nxt = S_ERR;
          end else if (tmr_ack) begin
            case (r_state)
              S_LD_PRE: w_state_nxt = S_PRE;
              S_LD_TST: w_state_nxt = S_TST;
              default:  w_state_nxt = S_WRM;
            endcase
          end else begin
            w_ack_cnt_nxt = r_ack_cnt + AW'(1);
          end
        end
        S_PRE, S_TST: begin
          if (!lid_closed) begin
            w_ret_nxt   = r_state;
            w_state_nxt = S_PAUSE;
          end else if (w_rem_zero) begin
            w_ack_cnt_nxt = '0;
            if (r_state == S_PRE) begin
              w_state_nxt = S_LD_TST;
            end else begin
              w_state_nxt  = S_LD_WRM;
              w_beep_start = 1'b1;
            end
          end
        end
        // Lever-up in keep-warm simply ends the cycle early.
        S_WRM: begin
          if (!lid_closed || w_rem_zero) w_state_nxt = S_IDLE;
        end
        S_PAUSE: begin
          if (lid_closed) w_state_nxt = r_ret;
        end
        S_ERR: w_state_nxt = S_ERR;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_beep_nxt = r_beep_cnt;
    if (cancel)                                  w_beep_nxt = '0;
    else if (w_beep_start && r_beep_cnt == '0)   w_beep_nxt = BW'(BEEP_CYC);
    else if (r_beep_cnt != '0)                   w_beep_nxt = r_beep_cnt - BW'(1);
  end

  // Outputs are decoded from the upcoming state so they register alongside it.
  always_comb begin
    w_nxt_bits  = w_state_nxt;
    w_eff       = (w_state_nxt == S_PAUSE) ? w_ret_nxt : w_state_nxt;
    w_tmr_write = (w_state_nxt == S_LD_PRE) || (w_state_nxt == S_LD_TST) || (w_state_nxt == S_LD_WRM);
    w_tmr_start = (w_state_nxt == S_PRE) || (w_state_nxt == S_TST) || (w_state_nxt == S_WRM);
    w_busy      = (w_state_nxt != S_IDLE) && (w_state_nxt != S_ERR);
    w_phase     = (w_state_nxt == S_ERR) ? 3'd7 : w_nxt_bits[2:0];
    w_err       = (w_state_nxt == S_ERR) || w_err_pulse;
    w_beep      = (w_beep_nxt != '0);
    w_tmr_time  = 10'd0;
    w_tmr_dc    = 8'd0;
    case (w_eff)
      S_LD_PRE: w_tmr_time = 10'(PREHEAT_S);
      S_PRE: begin
        w_tmr_time = 10'(PREHEAT_S);
        w_tmr_dc   = 8'(PREHEAT_DC);
      end
      S_LD_TST: w_tmr_time = r_cook;
      S_TST: begin
        w_tmr_time = r_cook;
        w_tmr_dc   = r_tdc;
      end
      S_LD_WRM: w_tmr_time = 10'(WARM_S);
      S_WRM: begin
        w_tmr_time = 10'(WARM_S);
        w_tmr_dc   = 8'(WARM_DC);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ret       <= S_PRE;
      r_ack_cnt   <= '0;
      r_beep_cnt  <= '0;
      r_tmr_write <= 1'b0;
      r_tmr_time  <= 10'd0;
      r_tmr_start <= 1'b0;
      r_tmr_dc    <= 8'd0;
      r_busy      <= 1'b0;
      r_beep      <= 1'b0;
      r_phase     <= 3'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ret       <= w_ret_nxt;
      r_ack_cnt   <= w_ack_cnt_nxt;
      r_beep_cnt  <= w_beep_nxt;
      r_tmr_write <= w_tmr_write;
      r_tmr_time  <= w_tmr_time;
      r_tmr_start <= w_tmr_start;
      r_tmr_dc    <= w_tmr_dc;
      r_busy      <= w_busy;
      r_beep      <= w_beep;
      r_phase     <= w_phase;
      r_err       <= w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap) begin
      r_cook <= cook_time;
      r_tdc  <= shade_dc(shade);
    end
  end

  assign tmr_write = r_tmr_write;
  assign tmr_time  = r_tmr_time;
  assign tmr_start = r_tmr_start;
  assign tmr_dc    = r_tmr_dc;
  assign busy      = r_busy;
  assign beep      = r_beep;
  assign phase     = r_phase;
  assign err       = r_err;

endmodule

// File: tb/tb_toast_sequencer.sv
// Bench for toast_sequencer: a timer stand-in, a phase-level reference model compared
// every cycle, and directed scenarios with hand-computed expectations.
module tb_toast_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0, cancel = 1'b0, lid_closed = 1'b1;
  logic [9:0]  cook_time = 10'd0;
  logic [1:0]  shade = 2'd0;
  logic [11:0] tmr_remaining = 12'd0;
  logic        tmr_ack = 1'b0;
  logic        tmr_write, tmr_start, busy, beep, err;
  logic [9:0]  tmr_time;
  logic [7:0]  tmr_dc;
  logic [2:0]  phase;

  toast_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .cancel(cancel), .lid_closed(lid_closed),
    .cook_time(cook_time), .shade(shade), .tmr_remaining(tmr_remaining), .tmr_ack(tmr_ack),
    .tmr_write(tmr_write), .tmr_time(tmr_time), .tmr_start(tmr_start), .tmr_dc(tmr_dc),
    .busy(busy), .beep(beep), .phase(phase), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Timer stand-in: acks a load at once, counts one "second" per enabled cycle.
  bit ack_en = 1'b1;
  int tcount = 0;
  int loads[$];
  always @(negedge clk) begin
    if (ack_en && tmr_write) begin
      tmr_ack = 1'b1;
      tcount  = int'(tmr_time);
      loads.push_back(int'(tmr_time));
    end else begin
      tmr_ack = 1'b0;
      if (tmr_start && tcount > 0) tcount--;
    end
    tmr_remaining = {4'(tcount / 60), 4'((tcount % 60) / 10), 4'(tcount % 10)};
  end

  // Reference model: phase numbers 0..7 as displayed, 8 stands for the error state.
  int m_ph = 0, m_ret = 0, m_cook = 0, m_dc = 0, m_cnt = 0, m_beep = 0;
  bit m_errp = 1'b0, m_done;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_ret = 0; m_cnt = 0; m_beep = 0; m_errp = 1'b0;
    end else begin
      m_errp = 1'b0;
      m_done = (tmr_remaining == 12'd0);
      if (cancel) m_beep = 0;
      else if (m_ph == 4 && lid_closed && m_done && m_beep == 0) m_beep = 1000;
      else if (m_beep > 0) m_beep--;
      if (cancel) m_ph = 0;
      else case (m_ph)
        0: if (go) begin
          if (lid_closed && cook_time >= 1 && cook_time <= 599) begin
            m_ph = 1; m_cnt = 0; m_cook = int'(cook_time); m_dc = 80 + 40 * int'(shade);
          end else m_errp = 1'b1;
        end
        1, 3, 5: begin
          m_cnt++;
          if (m_cnt == 16) m_ph = 8;
          else if (tmr_ack) m_ph = m_ph + 1;
        end
        2, 4: if (!lid_closed) begin
          m_ret = m_ph; m_ph = 7;
        end else if (m_done) begin
          m_ph = m_ph + 1; m_cnt = 0;
        end
        6: if (!lid_closed || m_done) m_ph = 0;
        7: if (lid_closed) m_ph = m_ret;
        default: ;
      endcase
    end
  end

  int e_eff, e_time, e_dc;
  always @(negedge clk) begin
    if (chk_on) begin
      e_eff  = (m_ph == 7) ? m_ret : m_ph;
      e_time = (e_eff == 1 || e_eff == 2) ? 20 : (e_eff == 3 || e_eff == 4) ? m_cook :
               (e_eff == 5 || e_eff == 6) ? 60 : 0;
      e_dc   = (e_eff == 2) ? 200 : (e_eff == 4) ? m_dc : (e_eff == 6) ? 40 : 0;
      check("model_write", tmr_write, (m_ph == 1 || m_ph == 3 || m_ph == 5));
      check("model_start", tmr_start, (m_ph == 2 || m_ph == 4 || m_ph == 6));
      check("model_time", tmr_time, e_time);
      check("model_dc", tmr_dc, e_dc);
      check("model_busy", busy, (m_ph != 0 && m_ph != 8));
      check("model_phase", phase, (m_ph == 8) ? 7 : m_ph);
      check("model_err", err, (m_ph == 8 || m_errp));
      check("model_beep", beep, (m_beep > 0));
    end
  end

  task automatic wait_phase(input int target, input int budget);
    int k = 0;
    while (phase !== 3'(target) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("wait_phase", phase, target);
  endtask

  task automatic pulse_go(input int ct, input int sh);
    cook_time = 10'(ct);
    shade     = 2'(sh);
    go        = 1'b1;
    @(negedge clk);
    go        = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_write"}, tmr_write, 0);
    check({tag, "_time"}, tmr_time, 0);
    check({tag, "_start"}, tmr_start, 0);
    check({tag, "_dc"}, tmr_dc, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_beep"}, beep, 0);
    check({tag, "_phase"}, phase, 0);
    check({tag, "_err"}, err, 0);
  endtask

  int phs[$];
  int exp_seq[7] = '{1, 2, 3, 4, 5, 6, 0};
  int exp_loads[3] = '{20, 5, 60};
  int last_ph, beep_cnt, beep_ph, dc_pre, dc_tst, dc_wrm;
  int bad_ct[3] = '{0, 600, 5};

  initial begin
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);

    // Normal cycle; inputs changed after go must not matter.
    loads.delete();
    last_ph = 0; beep_cnt = 0; beep_ph = -1; dc_pre = -1; dc_tst = -1; dc_wrm = -1;
    pulse_go(5, 2);
    check("go_latency_write", tmr_write, 1);
    check("go_latency_time", tmr_time, 20);
    cook_time = 10'd7;
    shade     = 2'd0;
    for (int i = 0; i < 1300; i++) begin
      if (int'(phase) != last_ph) begin
        phs.push_back(int'(phase));
        last_ph = int'(phase);
      end
      if (phase == 3'd2) dc_pre = int'(tmr_dc);
      if (phase == 3'd4) dc_tst = int'(tmr_dc);
      if (phase == 3'd6) dc_wrm = int'(tmr_dc);
      if (beep) begin
        if (beep_cnt == 0) beep_ph = int'(phase);
        beep_cnt++;
      end
      @(negedge clk);
    end
    check("seq_len", phs.size(), 7);
    for (int i = 0; i < 7; i++)
      check("seq_phase", (i < phs.size()) ? phs[i] : -1, exp_seq[i]);
    check("load_count", loads.size(), 3);
    for (int i = 0; i < 3; i++)
      check("load_value", (i < loads.size()) ? loads[i] : -1, exp_loads[i]);
    check("dc_pre", dc_pre, 200);
    check("dc_tst", dc_tst, 160);
    check("dc_wrm", dc_wrm, 40);
    check("beep_cycles", beep_cnt, 1000);
    check("beep_start_phase", beep_ph, 5);

    // Invalid go: zero time, too long, lever up.
    for (int i = 0; i < 3; i++) begin
      lid_closed = (i == 2) ? 1'b0 : 1'b1;
      pulse_go(bad_ct[i], 1);
      check("badgo_err", err, 1);
      check("badgo_phase", phase, 0);
      @(negedge clk);
      check("badgo_err_clear", err, 0);
      check("badgo_phase_hold", phase, 0);
    end
    lid_closed = 1'b1;

    // Pause and resume in the toast phase.
    pulse_go(30, 2);
    wait_phase(4, 200);
    repeat (5) @(negedge clk);
    lid_closed = 1'b0;
    @(negedge clk);
    check("pause_phase", phase, 7);
    check("pause_start", tmr_start, 0);
    check("pause_dc", tmr_dc, 160);
    repeat (499) @(negedge clk);
    check("pause_phase_late", phase, 7);
    check("pause_dc_late", tmr_dc, 160);
    lid_closed = 1'b1;
    @(negedge clk);
    check("resume_phase", phase, 4);
    check("resume_start", tmr_start, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    @(negedge clk);

    // Cancel during preheat.
    pulse_go(5, 1);
    wait_phase(2, 50);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check_all_zero("cancel_pre");

    // Cancel during the toast load.
    pulse_go(5, 1);
    wait_phase(3, 100);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check_all_zero("cancel_ldtst");

    // Ack never arrives.
    ack_en = 1'b0;
    pulse_go(5, 3);
    check("tmo_ld_phase", phase, 1);
    repeat (15) @(negedge clk);
    check("tmo_before_phase", phase, 1);
    check("tmo_before_err", err, 0);
    @(negedge clk);
    check("tmo_phase", phase, 7);
    check("tmo_err", err, 1);
    check("tmo_busy", busy, 0);
    check("tmo_write", tmr_write, 0);
    pulse_go(5, 3);
    @(negedge clk);
    check("tmo_go_ignored_phase", phase, 7);
    check("tmo_sticky_err", err, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("tmo_cancel_phase", phase, 0);
    check("tmo_cancel_err", err, 0);
    ack_en = 1'b1;

    // Asynchronous reset in the toast phase.
    pulse_go(30, 0);
    wait_phase(4, 200);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
